// File: rtl/ce_mcyc_ctl.sv
// ce_mcyc_ctl: sequencer for multi-cycle CorExtend ops in the HL/MAC result path.
// It accepts a qualified S-stage op and runs the iterative datapath for LAT
// unheld E-stage cycles, stalling the core while it runs. It then raises the
// registered result-select strobe. Single-cycle ops only pulse the select.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no op in flight; accepts new ops
//   BUSY  | multi-cycle op iterating; core halted; cnt = remaining iterations
//   DONE  | result cycle of a multi-cycle op; select high; accepts new ops
module ce_mcyc_ctl #(
   parameter int LAT        = 4,
   parameter int HALT_DRV_W = 4
) (
   input  logic                  CLK,
   input  logic                  RESET_D1_R_N,
   input  logic                  TMODE,
   input  logic                  CEI_CEHOLD,
   input  logic                  CEI_XCPN_M,
   input  logic [11:0]           CEI_OP_S_R,
   input  logic                  CEI_INSTM32_S_R_N,
   input  logic                  CFG_CEENBL,
   output logic                  DP_STEP_E,
   output logic                  DP_FIRST_E,
   output logic                  DP_LAST_E,
   output logic [3:0]            DP_CNT_E,
   output logic                  CE_SEL_E_R,
   output logic [HALT_DRV_W-1:0] CE_HALT_E_R_C
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

   state_t     st_q, st_d;
   logic [3:0] cnt_q, cnt_d;
   logic       sel_q, sel_d;

   logic       rst_eff;
   logic       q_any;
   logic       q_multi;
   logic       q_single;
   logic       busy;

   // Low bits of the op field carry the operation itself, not sequencing info.
   logic       unused_op_bits;
   assign unused_op_bits = ^CEI_OP_S_R[7:0];

   // Test mode masks reset so scan state is not disturbed.
   assign rst_eff  = !RESET_D1_R_N && !TMODE;

   // Op qualification. Hold and exception both suppress acceptance.
   assign q_any    = CEI_OP_S_R[11] && !CEI_INSTM32_S_R_N && CFG_CEENBL &&
                     !CEI_CEHOLD && !CEI_XCPN_M;
   assign q_multi  = q_any && (CEI_OP_S_R[10:8] == 3'b001);
   assign q_single = q_any && !q_multi;

   // State, counter and select registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (rst_eff) begin
         st_q  <= ST_IDLE;
         cnt_q <= 4'd0;
         sel_q <= 1'b0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         sel_q <= sel_d;
      end
   end

   // Next state: exception kills, hold freezes, otherwise sequence the op.
   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      sel_d = 1'b0;
      if (CEI_XCPN_M) begin
         st_d  = ST_IDLE;
         cnt_d = 4'd0;
         sel_d = 1'b0;
      end else if (CEI_CEHOLD) begin
         st_d  = st_q;
         cnt_d = cnt_q;
         sel_d = sel_q;
      end else begin
         unique case (st_q)
            ST_IDLE: begin
               if (q_multi) begin
                  st_d  = ST_BUSY;
                  cnt_d = LAT_M1;
               end else if (q_single) begin
                  sel_d = 1'b1;
               end
            end
            ST_BUSY: begin
               if (cnt_q != 4'd0) begin
                  cnt_d = cnt_q - 4'd1;
               end else begin
                  st_d  = ST_DONE;
                  sel_d = 1'b1;
               end
            end
            ST_DONE: begin
               // DONE accepts directly so back-to-back ops lose no cycle.
               if (q_multi) begin
                  st_d  = ST_BUSY;
                  cnt_d = LAT_M1;
               end else if (q_single) begin
                  st_d  = ST_IDLE;
                  sel_d = 1'b1;
               end else begin
                  st_d  = ST_IDLE;
               end
            end
            default: begin
               st_d  = ST_IDLE;
               cnt_d = 4'd0;
            end
         endcase
      end
   end

   // Datapath controls and stall, decoded from the registers plus hold only.
   always_comb begin
      busy          = (st_q == ST_BUSY);
      CE_HALT_E_R_C = {HALT_DRV_W{busy}};
      DP_STEP_E     = busy && !CEI_CEHOLD;
      DP_FIRST_E    = busy && (cnt_q == LAT_M1);
      DP_LAST_E     = busy && (cnt_q == 4'd0);
      DP_CNT_E      = cnt_q;
      CE_SEL_E_R    = sel_q;
   end

endmodule

// File: tb/tb_ce_mcyc_ctl.sv
// Testbench for ce_mcyc_ctl: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_ce_mcyc_ctl;

   localparam int LAT = 4;
   localparam int HW  = 4;

   logic          CLK = 1'b0;
   logic          RESET_D1_R_N;
   logic          TMODE;
   logic          CEI_CEHOLD;
   logic          CEI_XCPN_M;
   logic [11:0]   CEI_OP_S_R;
   logic          CEI_INSTM32_S_R_N;
   logic          CFG_CEENBL;
   logic          DP_STEP_E;
   logic          DP_FIRST_E;
   logic          DP_LAST_E;
   logic [3:0]    DP_CNT_E;
   logic          CE_SEL_E_R;
   logic [HW-1:0] CE_HALT_E_R_C;

   ce_mcyc_ctl #(.LAT(LAT), .HALT_DRV_W(HW)) dut (
      .CLK               (CLK),
      .RESET_D1_R_N      (RESET_D1_R_N),
      .TMODE             (TMODE),
      .CEI_CEHOLD        (CEI_CEHOLD),
      .CEI_XCPN_M        (CEI_XCPN_M),
      .CEI_OP_S_R        (CEI_OP_S_R),
      .CEI_INSTM32_S_R_N (CEI_INSTM32_S_R_N),
      .CFG_CEENBL        (CFG_CEENBL),
      .DP_STEP_E         (DP_STEP_E),
      .DP_FIRST_E        (DP_FIRST_E),
      .DP_LAST_E         (DP_LAST_E),
      .DP_CNT_E          (DP_CNT_E),
      .CE_SEL_E_R        (CE_SEL_E_R),
      .CE_HALT_E_R_C     (CE_HALT_E_R_C)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [HW-1:0] halt;
      logic          step;
      logic          first;
      logic          last;
      logic [3:0]    cnt;
      logic          sel;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: an op in flight is described by how many unheld
   // iterations it has reached (1..LAT); the result select is a one-cycle flag.
   bit   m_running = 0;
   int   m_age     = 0;
   bit   m_sel     = 0;

   task automatic chk(input string nm, input int act, input int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
      end
   endtask

   // One cycle: drive inputs, record what this cycle must show, advance model.
   task automatic cyc(input bit rst_n, input bit tm, input bit hold, input bit xc,
                      input logic [11:0] op, input bit inst_n, input bit en);
      exp_t e;
      bit   acc;
      bit   nsel;
      @(posedge CLK);
      #1;
      RESET_D1_R_N      = rst_n;
      TMODE             = tm;
      CEI_CEHOLD        = hold;
      CEI_XCPN_M        = xc;
      CEI_OP_S_R        = op;
      CEI_INSTM32_S_R_N = inst_n;
      CFG_CEENBL        = en;

      e.halt  = m_running ? {HW{1'b1}} : '0;
      e.step  = m_running && !hold;
      e.first = m_running && (m_age == 1);
      e.last  = m_running && (m_age == LAT);
      e.cnt   = m_running ? 4'(LAT - m_age) : 4'd0;
      e.sel   = m_sel;
      exp_q.push_back(e);

      if (!rst_n && !tm) begin
         m_running = 0; m_age = 0; m_sel = 0;
      end else if (xc) begin
         m_running = 0; m_age = 0; m_sel = 0;
      end else if (!hold) begin
         nsel = 0;
         if (m_running) begin
            if (m_age == LAT) begin
               m_running = 0;
               nsel      = 1;
            end else begin
               m_age++;
            end
         end else begin
            acc = op[11] && !inst_n && en;
            if (acc && op[10:8] == 3'b001) begin
               m_running = 1;
               m_age     = 1;
            end else if (acc) begin
               nsel = 1;
            end
         end
         m_sel = nsel;
      end
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 12'h000, 0, 1);
   endtask

   task automatic op1(input logic [11:0] op);
      cyc(1, 0, 0, 0, op, 0, 1);
   endtask

   // Monitor: compare every presented output cycle against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("halt",  int'(CE_HALT_E_R_C), int'(e.halt));
            chk("step",  int'(DP_STEP_E),     int'(e.step));
            chk("first", int'(DP_FIRST_E),    int'(e.first));
            chk("last",  int'(DP_LAST_E),     int'(e.last));
            chk("cnt",   int'(DP_CNT_E),      int'(e.cnt));
            chk("sel",   int'(CE_SEL_E_R),    int'(e.sel));
         end
      end
   end

   initial begin
      bit          hold, xc, rst_n, tm, inst_n, en;
      logic [11:0] op;
      logic [2:0]  cls;

      RESET_D1_R_N      = 1'b0;
      TMODE             = 1'b0;
      CEI_CEHOLD        = 1'b0;
      CEI_XCPN_M        = 1'b0;
      CEI_OP_S_R        = 12'h000;
      CEI_INSTM32_S_R_N = 1'b0;
      CFG_CEENBL        = 1'b1;
      repeat (2) @(posedge CLK);

      // Reset values held for a couple of cycles.
      cyc(0, 0, 0, 0, 12'h000, 0, 1);
      nop(1);

      // Multi-cycle op.
      op1(12'h900); nop(7);

      // Single-cycle op, then two ops that must not qualify.
      op1(12'h800); nop(2);
      cyc(1, 0, 0, 0, 12'h800, 1, 1); nop(2);
      cyc(1, 0, 0, 0, 12'h800, 0, 0); nop(2);

      // Hold for two cycles while cnt is 2.
      op1(12'h900); nop(1);
      cyc(1, 0, 1, 0, 12'h000, 0, 1);
      cyc(1, 0, 1, 0, 12'h000, 0, 1);
      nop(6);

      // Exception at t2 with a new S op in the same cycle.
      op1(12'h900); nop(1);
      cyc(1, 0, 0, 1, 12'h900, 0, 1);
      nop(6);

      // Exception in IDLE with an op present: op dropped.
      cyc(1, 0, 0, 1, 12'h800, 0, 1); nop(2);

      // Back-to-back multi-cycle ops via DONE.
      op1(12'h900); nop(4);
      op1(12'h900); nop(7);

      // Single-cycle op issued from DONE.
      op1(12'h9A5); nop(4);
      op1(12'h8FF); nop(3);

      // CEENBL falls mid-op: op completes.
      op1(12'h900);
      for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 12'h900, 0, 0);

      // Reset mid-BUSY, then the same with test mode masking it.
      op1(12'h900); nop(1);
      cyc(0, 0, 0, 0, 12'h000, 0, 1); nop(3);
      op1(12'h900); nop(1);
      cyc(0, 1, 0, 0, 12'h000, 0, 1); nop(6);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cls    = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'($urandom_range(0, 7));
         op     = {1'($urandom_range(0, 99) < 60), cls, 8'($urandom_range(0, 255))};
         hold   = $urandom_range(0, 99) < 15;
         xc     = $urandom_range(0, 99) < 4;
         rst_n  = $urandom_range(0, 99) >= 2;
         tm     = $urandom_range(0, 99) < 30;
         inst_n = $urandom_range(0, 99) < 10;
         en     = $urandom_range(0, 99) >= 10;
         cyc(rst_n, tm, hold, xc, op, inst_n, en);
      end
      nop(2);

      @(posedge CLK);
      @(negedge CLK);
      @(posedge CLK);
      chk("drain", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
